// File: rtl/poly_pipe_arbiter.sv
// Round-robin front end for a shared fixed-latency polynomial pipeline.
// Clients post operands, one is granted per cycle and its operand is driven
// to the pipeline. A tag shift register follows each operand so that the
// result can be returned with the ID of the client that issued it.
// After reset, grants are held off for a few cycles so that pipelines
// sitting behind a registered reset tree are out of reset before first use.

module poly_pipe_arbiter #(
   parameter  int WIDTH          = 8,
   parameter  int NUM_REQUESTERS = 4,
   parameter  int PIPE_LATENCY   = 4,
   parameter  int RST_HOLDOFF    = 4,
   localparam int ID_W           = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQUESTERS-1:0]       req_valid,
   input  logic [NUM_REQUESTERS*WIDTH-1:0] req_x,
   output logic [NUM_REQUESTERS-1:0]       req_ready,
   output logic [WIDTH-1:0]                pipe_x,
   input  logic [4*WIDTH-1:0]              pipe_out,
   output logic                            resp_valid,
   output logic [ID_W-1:0]                 resp_id,
   output logic [4*WIDTH-1:0]              resp_data,
   output logic                            busy
);

   localparam int HOLD_W = (RST_HOLDOFF > 0) ? $clog2(RST_HOLDOFF + 1) : 1;

   logic [HOLD_W-1:0]       hold_cnt;
   logic [ID_W-1:0]         rr_ptr;
   logic                    grant;
   logic [ID_W-1:0]         grant_id;
   logic [PIPE_LATENCY-1:0] tag_v;
   logic [ID_W-1:0]         tag_id [PIPE_LATENCY];

   // Holdoff down-counter: reloaded while in reset, saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= HOLD_W'(RST_HOLDOFF);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end

   // Round-robin search starting at the pointer, wrapping past the top index.
   always_comb begin
      int idx;
      logic [ID_W-1:0] cand;
      grant    = 1'b0;
      grant_id = '0;
      idx      = 0;
      cand     = '0;
      if (!rst && hold_cnt == '0) begin
         for (int k = 0; k < NUM_REQUESTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQUESTERS) begin
               idx = idx - NUM_REQUESTERS;
            end
            cand = ID_W'(idx);
            if (!grant && req_valid[cand]) begin
               grant    = 1'b1;
               grant_id = cand;
            end
         end
      end
   end

   // One-hot grant and operand mux toward the pipeline (zero when idle).
   always_comb begin
      req_ready = '0;
      pipe_x    = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (grant && grant_id == ID_W'(i)) begin
            req_ready[i] = 1'b1;
            pipe_x       = req_x[i*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer moves just past the winner; stays put when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (grant_id == ID_W'(NUM_REQUESTERS - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   // Tag valid bits track the pipeline; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
      end else begin
         tag_v[0] <= grant;
         for (int i = 1; i < PIPE_LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
         end
      end
   end

   // Tag IDs only matter alongside a valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
         tag_id[i] <= tag_id[i-1];
      end
   end

   // Capture the pipeline result while the last tag is valid; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= tag_v[PIPE_LATENCY-1];
         if (tag_v[PIPE_LATENCY-1]) begin
            resp_id   <= tag_id[PIPE_LATENCY-1];
            resp_data <= pipe_out;
         end
      end
   end

   // Busy covers holdoff, anything in the pipeline and the response register.
   always_comb begin
      busy = (hold_cnt != '0) || (|tag_v) || resp_valid;
   end

endmodule
